// File: rtl/crop_paste_pkg.sv
// Shared constants and state encoding for the crop / paste family of blocks.
package crop_paste_pkg;

  localparam int unsigned CP_PIXEL_BIT_WIDTH  = 12;
  localparam int unsigned CP_IN_ROWS          = 20;
  localparam int unsigned CP_IN_COLS          = 20;
  localparam int unsigned CP_OUT_ROWS         = 40;
  localparam int unsigned CP_OUT_COLS         = 40;
  localparam int unsigned CP_IMG_ROW_BITWIDTH = 10;
  localparam int unsigned CP_IMG_COL_BITWIDTH = 10;
  localparam int unsigned CP_FILL_VALUE       = 0;

  // Largest legal window origin so the window never runs off the frame.
  function automatic int unsigned clamp_limit(input int unsigned out_n, input int unsigned in_n);
    return (out_n > in_n) ? (out_n - in_n) : 0;
  endfunction

  localparam int unsigned CP_ROW_LIMIT = clamp_limit(CP_OUT_ROWS, CP_IN_ROWS);
  localparam int unsigned CP_COL_LIMIT = clamp_limit(CP_OUT_COLS, CP_IN_COLS);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } crop_state_e;

endpackage

// File: rtl/crop_paste_coord_capture.sv
// Independent Y1/X1 stream handshakes with clamping; reports when both are held.
module crop_paste_coord_capture
  import crop_paste_pkg::*;
#(
  parameter int unsigned ROW_W    = CP_IMG_ROW_BITWIDTH,
  parameter int unsigned COL_W    = CP_IMG_COL_BITWIDTH,
  parameter int unsigned IN_ROWS  = CP_IN_ROWS,
  parameter int unsigned IN_COLS  = CP_IN_COLS,
  parameter int unsigned OUT_ROWS = CP_OUT_ROWS,
  parameter int unsigned OUT_COLS = CP_OUT_COLS
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic [ROW_W-1:0] i_y1_data,
  input  logic             i_y1_valid,
  output logic             o_y1_ready,
  input  logic [COL_W-1:0] i_x1_data,
  input  logic             i_x1_valid,
  output logic             o_x1_ready,
  output logic [ROW_W-1:0] o_y1,
  output logic [COL_W-1:0] o_x1,
  output logic             o_both
);

  localparam logic [ROW_W-1:0] Y_MAX = ROW_W'(clamp_limit(OUT_ROWS, IN_ROWS));
  localparam logic [COL_W-1:0] X_MAX = COL_W'(clamp_limit(OUT_COLS, IN_COLS));

  logic             r_y_cap;
  logic             r_x_cap;
  logic             r_y_rdy;
  logic             r_x_rdy;
  logic [ROW_W-1:0] r_y1;
  logic [COL_W-1:0] r_x1;
  logic             w_y_hs;
  logic             w_x_hs;

  assign w_y_hs = i_y1_valid && r_y_rdy;
  assign w_x_hs = i_x1_valid && r_x_rdy;

  // Ready is registered: it drops the cycle after capture and stays low until cleared.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_y_cap <= 1'b0;
      r_x_cap <= 1'b0;
      r_y_rdy <= 1'b0;
      r_x_rdy <= 1'b0;
      r_y1    <= '0;
      r_x1    <= '0;
    end else begin
      if (i_clear) begin
        r_y_cap <= 1'b0;
        r_y_rdy <= 1'b1;
      end else if (w_y_hs) begin
        r_y_cap <= 1'b1;
        r_y_rdy <= 1'b0;
        r_y1    <= (i_y1_data > Y_MAX) ? Y_MAX : i_y1_data;
      end else begin
        r_y_rdy <= !r_y_cap;
      end

      if (i_clear) begin
        r_x_cap <= 1'b0;
        r_x_rdy <= 1'b1;
      end else if (w_x_hs) begin
        r_x_cap <= 1'b1;
        r_x_rdy <= 1'b0;
        r_x1    <= (i_x1_data > X_MAX) ? X_MAX : i_x1_data;
      end else begin
        r_x_rdy <= !r_x_cap;
      end
    end
  end

  assign o_y1_ready = r_y_rdy;
  assign o_x1_ready = r_x_rdy;
  assign o_y1       = r_y1;
  assign o_x1       = r_x1;
  assign o_both     = r_y_cap && r_x_cap;

endmodule

// File: rtl/crop_paste.sv
// Re-embeds a cropped window stream into a full frame at (Y1, X1), filling the rest.
module crop_paste
  import crop_paste_pkg::*;
#(
  parameter int unsigned PIXEL_BIT_WIDTH  = CP_PIXEL_BIT_WIDTH,
  parameter int unsigned IN_ROWS          = CP_IN_ROWS,
  parameter int unsigned IN_COLS          = CP_IN_COLS,
  parameter int unsigned OUT_ROWS         = CP_OUT_ROWS,
  parameter int unsigned OUT_COLS         = CP_OUT_COLS,
  parameter int unsigned IMG_ROW_BITWIDTH = CP_IMG_ROW_BITWIDTH,
  parameter int unsigned IMG_COL_BITWIDTH = CP_IMG_COL_BITWIDTH,
  parameter int unsigned FILL_VALUE       = CP_FILL_VALUE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PIXEL_BIT_WIDTH-1:0]  window_in_TDATA,
  input  logic                        window_in_TVALID,
  output logic                        window_in_TREADY,
  input  logic [IMG_ROW_BITWIDTH-1:0] paste_Y1_TDATA,
  input  logic                        paste_Y1_TVALID,
  output logic                        paste_Y1_TREADY,
  input  logic [IMG_COL_BITWIDTH-1:0] paste_X1_TDATA,
  input  logic                        paste_X1_TVALID,
  output logic                        paste_X1_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0]  pixel_out_TDATA,
  output logic                        pixel_out_TVALID,
  input  logic                        pixel_out_TREADY,
  output logic                        pixel_out_TLAST
);

  localparam int unsigned RW1 = IMG_ROW_BITWIDTH + 1;
  localparam int unsigned CW1 = IMG_COL_BITWIDTH + 1;
  localparam logic [IMG_ROW_BITWIDTH-1:0] LAST_ROW = IMG_ROW_BITWIDTH'(OUT_ROWS - 1);
  localparam logic [IMG_COL_BITWIDTH-1:0] LAST_COL = IMG_COL_BITWIDTH'(OUT_COLS - 1);
  localparam logic [PIXEL_BIT_WIDTH-1:0]  FILL     = PIXEL_BIT_WIDTH'(FILL_VALUE);

  crop_state_e                 r_state;
  logic [IMG_ROW_BITWIDTH-1:0] r_row;
  logic [IMG_COL_BITWIDTH-1:0] r_col;
  logic [PIXEL_BIT_WIDTH-1:0]  r_data;
  logic                        r_valid;
  logic                        r_last;

  logic [IMG_ROW_BITWIDTH-1:0] w_y1;
  logic [IMG_COL_BITWIDTH-1:0] w_x1;
  logic                        w_both;
  logic [RW1-1:0]              w_row_end;
  logic [CW1-1:0]              w_col_end;
  logic                        w_inside;
  logic                        w_streaming;
  logic                        w_load_ok;
  logic                        w_load;
  logic                        w_last_pos;
  logic                        w_clear;

  crop_paste_coord_capture #(
    .ROW_W    (IMG_ROW_BITWIDTH),
    .COL_W    (IMG_COL_BITWIDTH),
    .IN_ROWS  (IN_ROWS),
    .IN_COLS  (IN_COLS),
    .OUT_ROWS (OUT_ROWS),
    .OUT_COLS (OUT_COLS)
  ) u_coord (
    .clk        (clk),
    .i_rst_n    (reset),
    .i_clear    (w_clear),
    .i_y1_data  (paste_Y1_TDATA),
    .i_y1_valid (paste_Y1_TVALID),
    .o_y1_ready (paste_Y1_TREADY),
    .i_x1_data  (paste_X1_TDATA),
    .i_x1_valid (paste_X1_TVALID),
    .o_x1_ready (paste_X1_TREADY),
    .o_y1       (w_y1),
    .o_x1       (w_x1),
    .o_both     (w_both)
  );

  // Window bounds are exclusive ends, widened by one bit so they cannot wrap.
  assign w_row_end   = {1'b0, w_y1} + RW1'(IN_ROWS);
  assign w_col_end   = {1'b0, w_x1} + CW1'(IN_COLS);
  assign w_inside    = (r_row >= w_y1) && ({1'b0, r_row} < w_row_end) &&
                       (r_col >= w_x1) && ({1'b0, r_col} < w_col_end);
  assign w_streaming = (r_state == ST_STREAM);
  assign w_load_ok   = !r_valid || pixel_out_TREADY;
  assign w_load      = w_streaming && w_load_ok && (!w_inside || window_in_TVALID);
  assign w_last_pos  = (r_row == LAST_ROW) && (r_col == LAST_COL);
  assign w_clear     = w_load && w_last_pos;

  assign window_in_TREADY = w_streaming && w_inside && w_load_ok;

  // Frame walker, state and single output register stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      if (w_load_ok) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
      if (r_state == ST_IDLE) begin
        if (w_both) begin
          r_state <= ST_STREAM;
        end
      end else if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_inside ? window_in_TDATA : FILL;
        r_last  <= w_last_pos;
        if (w_last_pos) begin
          r_state <= ST_IDLE;
          r_row   <= '0;
          r_col   <= '0;
        end else if (r_col == LAST_COL) begin
          r_col <= '0;
          r_row <= r_row + IMG_ROW_BITWIDTH'(1);
        end else begin
          r_col <= r_col + IMG_COL_BITWIDTH'(1);
        end
      end
    end
  end

  assign pixel_out_TDATA  = r_data;
  assign pixel_out_TVALID = r_valid;
  assign pixel_out_TLAST  = r_last;

endmodule

// File: tb/tb_crop_paste.sv
// Scoreboard bench for crop_paste: expected frames queued at stimulus time, popped on output handshakes.
`timescale 1ns/1ps
module tb_crop_paste;

  localparam int PW = 12;
  localparam int RW = 10;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [PW-1:0] window_in_TDATA = '0;
  logic          window_in_TVALID = 1'b0;
  logic          window_in_TREADY;
  logic [RW-1:0] paste_Y1_TDATA = '0;
  logic          paste_Y1_TVALID = 1'b0;
  logic          paste_Y1_TREADY;
  logic [CW-1:0] paste_X1_TDATA = '0;
  logic          paste_X1_TVALID = 1'b0;
  logic          paste_X1_TREADY;
  logic [PW-1:0] pixel_out_TDATA;
  logic          pixel_out_TVALID;
  logic          pixel_out_TREADY = 1'b1;
  logic          pixel_out_TLAST;

  always #5 clk = ~clk;

  crop_paste dut (
    .clk              (clk),
    .reset            (reset),
    .window_in_TDATA  (window_in_TDATA),
    .window_in_TVALID (window_in_TVALID),
    .window_in_TREADY (window_in_TREADY),
    .paste_Y1_TDATA   (paste_Y1_TDATA),
    .paste_Y1_TVALID  (paste_Y1_TVALID),
    .paste_Y1_TREADY  (paste_Y1_TREADY),
    .paste_X1_TDATA   (paste_X1_TDATA),
    .paste_X1_TVALID  (paste_X1_TVALID),
    .paste_X1_TREADY  (paste_X1_TREADY),
    .pixel_out_TDATA  (pixel_out_TDATA),
    .pixel_out_TVALID (pixel_out_TVALID),
    .pixel_out_TREADY (pixel_out_TREADY),
    .pixel_out_TLAST  (pixel_out_TLAST)
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int n_out = 0;
  int n_extra = 0;
  int tlast_cnt = 0;
  int cyc = 0;
  int first_cyc = -1;
  int last_cyc = -1;
  bit rand_ready = 1'b0;
  bit rand_valid = 1'b0;
  bit abort = 1'b0;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference frame: window pixels base.. in raster order, clamped origin, fill 0, TLAST at bit 16.
  task automatic push_frame(input int y, input int x, input int base);
    int yc, xc, d;
    yc = (y > 20) ? 20 : y;
    xc = (x > 20) ? 20 : x;
    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < 40; c++) begin
        if (r >= yc && r < yc + 20 && c >= xc && c < xc + 20)
          d = base + (r - yc) * 20 + (c - xc);
        else
          d = 0;
        if (r == 39 && c == 39) d = d | (1 << 16);
        exp_q.push_back(d);
      end
    end
  endtask

  // Output monitor: stability while stalled, scoreboard pop on handshake.
  initial begin
    logic          p_valid, p_ready, p_last, p_rst;
    logic [PW-1:0] p_data;
    int            e;
    p_valid = 0; p_ready = 0; p_last = 0; p_rst = 0; p_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset && p_rst && p_valid && !p_ready) begin
        chk("hold_valid", int'(pixel_out_TVALID), 1);
        chk("hold_data", int'(pixel_out_TDATA), int'(p_data));
        chk("hold_last", int'(pixel_out_TLAST), int'(p_last));
      end
      if (reset && pixel_out_TVALID) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (pixel_out_TREADY) begin
          n_out++;
          if (pixel_out_TLAST) begin
            tlast_cnt++;
            last_cyc = cyc;
          end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pix_data", int'(pixel_out_TDATA), e & 32'hfff);
            chk("pix_last", int'(pixel_out_TLAST), (e >> 16) & 1);
          end else begin
            n_extra++;
          end
        end
      end
      p_valid = pixel_out_TVALID;
      p_ready = pixel_out_TREADY;
      p_data  = pixel_out_TDATA;
      p_last  = pixel_out_TLAST;
      p_rst   = reset;
    end
  end

  // Downstream back-pressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      pixel_out_TREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_coord(input bit is_y, input int v, output bit ok);
    int g;
    bit hs;
    g = 0;
    hs = 1'b0;
    if (is_y) begin
      paste_Y1_TDATA = RW'(v);
      paste_Y1_TVALID = 1'b1;
    end else begin
      paste_X1_TDATA = CW'(v);
      paste_X1_TVALID = 1'b1;
    end
    while (!hs && g < 6000 && !abort) begin
      @(negedge clk);
      hs = is_y ? (paste_Y1_TVALID && paste_Y1_TREADY) : (paste_X1_TVALID && paste_X1_TREADY);
      @(posedge clk);
      #1;
      g++;
    end
    if (is_y) paste_Y1_TVALID = 1'b0;
    else      paste_X1_TVALID = 1'b0;
    ok = hs;
  endtask

  task automatic send_window(input int n, input int base, output int sent);
    int g;
    bit hs;
    g = 0;
    sent = 0;
    while (sent < n && g < 20000 && !abort) begin
      if (!window_in_TVALID) begin
        window_in_TVALID = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
        window_in_TDATA  = PW'(base + sent);
      end
      @(negedge clk);
      hs = window_in_TVALID && window_in_TREADY;
      @(posedge clk);
      #1;
      g++;
      if (hs) begin
        sent++;
        window_in_TVALID = 1'b0;
      end
    end
    window_in_TVALID = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < budget) begin
      @(negedge clk);
      g++;
    end
    chk("drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int y, input int x, input int base);
    bit oky, okx;
    int sent;
    push_frame(y, x, base);
    fork
      send_coord(1'b1, y, oky);
      send_coord(1'b0, x, okx);
      send_window(400, base, sent);
    join
    chk("y_hs", int'(oky), 1);
    chk("x_hs", int'(okx), 1);
    chk("win_consumed", sent, 400);
    wait_drain(20000);
    chk("idle_win_rdy", int'(window_in_TREADY), 0);
  endtask

  initial begin
    bit oky, okx, oky2, okx2;
    int sent, sent2, out0, t0, g;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(pixel_out_TVALID), 0);
    chk("rst_data", int'(pixel_out_TDATA), 0);
    chk("rst_last", int'(pixel_out_TLAST), 0);
    chk("rst_win_rdy", int'(window_in_TREADY), 0);
    chk("rst_y_rdy", int'(paste_Y1_TREADY), 0);
    chk("rst_x_rdy", int'(paste_X1_TREADY), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full-rate frame with latency check
    first_cyc = -1;
    run_frame(10, 5, 1);
    chk("frame_span", last_cyc - first_cyc, 1599);
    chk("tlast_f1", tlast_cnt, 1);

    // Random back-pressure and window gaps
    rand_ready = 1'b1;
    rand_valid = 1'b1;
    run_frame(10, 5, 1);
    rand_ready = 1'b0;
    rand_valid = 1'b0;

    // X leads Y by 7 cycles; both clamp
    push_frame(35, 30, 1);
    fork
      send_coord(1'b0, 30, okx);
      begin
        repeat (7) @(posedge clk);
        #1;
        chk("x_rdy_after_cap", int'(paste_X1_TREADY), 0);
        chk("y_rdy_waiting", int'(paste_Y1_TREADY), 1);
        chk("no_out_before_y", int'(pixel_out_TVALID), 0);
        send_coord(1'b1, 35, oky);
      end
      send_window(400, 1, sent);
    join
    chk("clamp_x_hs", int'(okx), 1);
    chk("clamp_y_hs", int'(oky), 1);
    chk("clamp_win_consumed", sent, 400);
    wait_drain(20000);

    // Reset mid-frame at output pixel 700
    out0 = n_out;
    push_frame(10, 5, 1);
    fork
      send_coord(1'b1, 10, oky);
      send_coord(1'b0, 5, okx);
      send_window(400, 1, sent);
      begin
        g = 0;
        while (n_out - out0 < 700 && g < 5000) begin
          @(negedge clk);
          g++;
        end
        chk("reached_700", int'(n_out - out0 >= 700), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_valid", int'(pixel_out_TVALID), 0);
        chk("abort_last", int'(pixel_out_TLAST), 0);
        chk("abort_win_rdy", int'(window_in_TREADY), 0);
        chk("abort_y_rdy", int'(paste_Y1_TREADY), 0);
        chk("abort_x_rdy", int'(paste_X1_TREADY), 0);
        abort = 1'b1;
      end
    join
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    abort = 1'b0;
    run_frame(0, 0, 1);

    // Back-to-back frames; second coords held off until frame 1's last pixel loads
    t0 = tlast_cnt;
    push_frame(0, 20, 1);
    push_frame(20, 0, 1001);
    fork
      begin
        send_coord(1'b1, 0, oky);
        send_coord(1'b1, 20, oky2);
        chk("y2_after_f1_last", tlast_cnt - t0, 1);
      end
      begin
        send_coord(1'b0, 20, okx);
        send_coord(1'b0, 0, okx2);
        chk("x2_after_f1_last", tlast_cnt - t0, 1);
      end
      begin
        send_window(400, 1, sent);
        send_window(400, 1001, sent2);
      end
    join
    chk("b2b_y_hs", int'(oky && oky2), 1);
    chk("b2b_x_hs", int'(okx && okx2), 1);
    chk("b2b_win1", sent, 400);
    chk("b2b_win2", sent2, 400);
    wait_drain(20000);
    chk("b2b_tlast_twice", tlast_cnt - t0, 2);

    chk("extra_outputs", n_extra, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
